// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: walks one AES block through external SubBytes/ShiftRows/MixColumns/AddRoundKey
// engines, owning the state register and the round index, with a per-stage timeout.
module aes_round_sequencer #(
  parameter int NUM_ROUNDS     = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [127:0] plaintext,
  output logic [127:0] state_out,
  output logic [3:0]   stage_valid,
  input  logic [3:0]   stage_ready,
  input  logic [3:0]   stage_done,
  output logic [3:0]   stage_ack,
  input  logic [511:0] stage_result,
  output logic [3:0]   round,
  output logic         done_valid,
  input  logic         done_ready,
  output logic [127:0] ciphertext,
  output logic         busy,
  output logic         error
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] ARK = 2'd3;
  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERROR} fsm_t;

  if (NUM_ROUNDS != 10 && NUM_ROUNDS != 12 && NUM_ROUNDS != 14) begin : g_bad_rounds
    $error("aes_round_sequencer: NUM_ROUNDS must be 10, 12 or 14");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("aes_round_sequencer: TIMEOUT_CYCLES must be at least 2");
  end

  fsm_t            fsm_q, fsm_d;
  logic [127:0]    state_q, state_d;
  logic [3:0]      round_q, round_d;
  logic [1:0]      sel_q, sel_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [TW-1:0]   timer_inc;
  logic            fire, last, timeout;

  assign fire      = fsm_q == WAIT && stage_done[sel_q];
  assign last      = sel_q == ARK && round_q == LAST;
  assign timer_inc = (timer_q == TMAX) ? timer_q : timer_q + 1'b1;
  // ERROR lands on the edge where the count reaches the limit, so a stage gets exactly TIMEOUT_CYCLES cycles
  assign timeout   = timer_inc == TMAX;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    sel_d   = sel_q;
    timer_d = timer_q;
    case (fsm_q)
      IDLE: if (start_valid) begin
        fsm_d   = ISSUE;
        state_d = plaintext;
        round_d = '0;
        sel_d   = ARK;
        timer_d = '0;
      end
      ISSUE: begin
        timer_d = timer_inc;
        fsm_d   = timeout ? ERROR : stage_ready[sel_q] ? WAIT : ISSUE;
      end
      WAIT: if (fire) begin
        state_d = stage_result[{sel_q, 7'd0} +: 128];
        timer_d = '0;
        fsm_d   = last ? DONE : ISSUE;
        // final round skips MIX; ARK wraps to SUB and opens the next round
        sel_d   = last ? sel_q : (sel_q == SHIFT && round_q == LAST) ? ARK : sel_q + 2'd1;
        round_d = (sel_q == ARK && !last) ? round_q + 4'd1 : round_q;
      end else begin
        timer_d = timer_inc;
        fsm_d   = timeout ? ERROR : WAIT;
      end
      DONE: fsm_d = done_ready ? IDLE : DONE;
      default: fsm_d = ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= '0;
      sel_q   <= ARK;
      timer_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
      sel_q   <= sel_d;
      timer_q <= timer_d;
    end
  end

  assign start_ready = fsm_q == IDLE;
  assign stage_valid = (fsm_q == ISSUE) ? 4'b0001 << sel_q : 4'b0000;
  assign stage_ack   = fire ? 4'b0001 << sel_q : 4'b0000;
  assign state_out   = state_q;
  assign ciphertext  = state_q;
  assign round       = round_q;
  assign done_valid  = fsm_q == DONE;
  assign busy        = fsm_q == ISSUE || fsm_q == WAIT || fsm_q == DONE;
  assign error       = fsm_q == ERROR;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: two sequencers (AES-128 and AES-256) driving golden AES stage engines
// with a 16-cycle latency; directed scenarios with known FIPS-197 vectors.
module tb_aes_round_sequencer;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [1:0]   start_valid = 2'b00;
  logic [1:0]   done_ready = 2'b00;
  logic         mix_hang = 1'b0;
  logic [127:0] plaintext [2];
  logic [127:0] state_out [2];
  logic [127:0] ciphertext [2];
  logic [3:0]   stage_valid [2];
  logic [3:0]   stage_ack [2];
  logic [3:0]   round [2];
  logic         start_ready [2];
  logic         done_valid [2];
  logic         busy [2];
  logic         error [2];
  wire  [3:0]   stage_ready [2];
  wire  [3:0]   stage_done [2];
  wire  [511:0] stage_result [2];
  logic [127:0] rk [2][15];
  logic [7:0]   tr0 [$];
  logic [7:0]   tr1 [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction

  // S-box from first principles: x^254 inverse then the affine map
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] sq, r;
    sq = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r = gmul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
  endfunction

  function automatic logic [127:0] stage_fn(input int s, input logic [127:0] st, input logic [127:0] key);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = st;
    if (s == 0) begin
      for (int k = 0; k < 16; k++) o[127-8*k -: 8] = sb(st[127-8*k -: 8]);
    end else if (s == 1) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) o[127-8*(r+4*c) -: 8] = st[127-8*(r+4*((c+r)%4)) -: 8];
    end else if (s == 2) begin
      for (int c = 0; c < 4; c++) begin
        a0 = st[127-32*c -: 8];
        a1 = st[119-32*c -: 8];
        a2 = st[111-32*c -: 8];
        a3 = st[103-32*c -: 8];
        o[127-32*c -: 8] = xt(a0) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        o[119-32*c -: 8] = a0 ^ xt(a1) ^ gmul(a2, 8'h03) ^ a3;
        o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ gmul(a3, 8'h03);
        o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ xt(a3);
      end
    end else begin
      o = st ^ key;
    end
    return o;
  endfunction

  task automatic expand(input int g, input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk[g][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int NR = (g == 1) ? 14 : 10;
    aes_round_sequencer #(.NUM_ROUNDS(NR), .TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .reset_n(reset_n),
      .start_valid(start_valid[g]), .start_ready(start_ready[g]), .plaintext(plaintext[g]),
      .state_out(state_out[g]), .stage_valid(stage_valid[g]), .stage_ready(stage_ready[g]),
      .stage_done(stage_done[g]), .stage_ack(stage_ack[g]), .stage_result(stage_result[g]),
      .round(round[g]), .done_valid(done_valid[g]), .done_ready(done_ready[g]),
      .ciphertext(ciphertext[g]), .busy(busy[g]), .error(error[g])
    );
    for (genvar s = 0; s < 4; s++) begin : g_stage
      logic busy_m, done_m;
      int cnt;
      logic [127:0] res;
      assign stage_ready[g][s] = !busy_m;
      assign stage_done[g][s] = done_m;
      assign stage_result[g][s*128 +: 128] = res;
      always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          busy_m <= 1'b0;
          done_m <= 1'b0;
          cnt <= 0;
          res <= '0;
        end else if (!busy_m) begin
          if (stage_valid[g][s]) begin
            busy_m <= 1'b1;
            cnt <= 0;
            res <= stage_fn(s, state_out[g], rk[g][round[g]]);
          end
        end else if (done_m) begin
          if (stage_ack[g][s]) begin
            busy_m <= 1'b0;
            done_m <= 1'b0;
          end
        end else if (cnt == 15) begin
          done_m <= !(mix_hang && g == 0 && s == 2);
        end else begin
          cnt <= cnt + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (stage_ack[0] != 4'b0) tr0.push_back({round[0], stage_ack[0]});
    if (stage_ack[1] != 4'b0) tr1.push_back({round[1], stage_ack[1]});
  end

  task automatic start_block(input int g, input logic [127:0] pt);
    @(negedge clk);
    plaintext[g] = pt;
    start_valid[g] = 1'b1;
    @(negedge clk);
    start_valid[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done_valid[g] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_reset;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    #1 reset_n = 1'b0;
    #2;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (state_out[g] !== 128'h0 || ciphertext[g] !== 128'h0) begin
        errors++;
        $display("FAIL reset_data[%0d]: state_out=%h ciphertext=%h, want 0", g, state_out[g], ciphertext[g]);
      end
      checks++;
      if ({start_ready[g], done_valid[g], busy[g], error[g]} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_flags[%0d]: {start_ready,done_valid,busy,error}=%b, want 1000", g,
                 {start_ready[g], done_valid[g], busy[g], error[g]});
      end
      checks++;
      if ({stage_valid[g], stage_ack[g], round[g]} !== 12'h000) begin
        errors++;
        $display("FAIL reset_stage[%0d]: valid=%b ack=%b round=%0d, want 0", g, stage_valid[g], stage_ack[g], round[g]);
      end
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_c1;
    bit ok;
    tr0.delete();
    start_block(0, PT);
    wait_done(0, 3000, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL c1_complete: done_valid never rose within 3000 cycles, want 1");
    end
    checks++;
    if (ciphertext[0] !== CT1) begin
      errors++;
      $display("FAIL c1_ct: got %h, want %h", ciphertext[0], CT1);
    end
  endtask

  task automatic test_stage_trace;
    logic [7:0] exp [$];
    logic [7:0] got;
    exp.push_back({4'd0, 4'b1000});
    for (int r = 1; r < 10; r++) begin
      exp.push_back({4'(r), 4'b0001});
      exp.push_back({4'(r), 4'b0010});
      exp.push_back({4'(r), 4'b0100});
      exp.push_back({4'(r), 4'b1000});
    end
    exp.push_back({4'd10, 4'b0001});
    exp.push_back({4'd10, 4'b0010});
    exp.push_back({4'd10, 4'b1000});
    checks++;
    if (tr0.size() != 40) begin
      errors++;
      $display("FAIL trace_acks: got %0d acks, want 40", tr0.size());
    end
    for (int i = 0; i < 40; i++) begin
      got = (i < tr0.size()) ? tr0[i] : 8'hxx;
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL trace[%0d]: round/ack got %h, want %h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_done_hold;
    logic [127:0] ct;
    ct = ciphertext[0];
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (done_valid[0] !== 1'b1 || ciphertext[0] !== ct || start_ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
        errors++;
        $display("FAIL hold[%0d]: done_valid=%b start_ready=%b busy=%b ct=%h, want 1/0/1 %h", i,
                 done_valid[0], start_ready[0], busy[0], ciphertext[0], ct);
      end
    end
    done_ready[0] = 1'b1;
    @(negedge clk);
    done_ready[0] = 1'b0;
    checks++;
    if (start_ready[0] !== 1'b1 || done_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL release: start_ready=%b done_valid=%b busy=%b, want 1/0/0", start_ready[0], done_valid[0], busy[0]);
    end
  endtask

  task automatic test_reset_mid_block;
    bit found, ok;
    found = 1'b0;
    start_block(0, PT);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (round[0] == 4'd5 && busy[0] && stage_valid[0] == 4'b0 && !done_valid[0]) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (found !== 1'b1) begin
      errors++;
      $display("FAIL midreset_reach: round 5 WAIT not seen, got %b want 1", found);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (state_out[0] !== 128'h0 || round[0] !== 4'd0) begin
      errors++;
      $display("FAIL midreset_state: state_out=%h round=%0d, want 0/0", state_out[0], round[0]);
    end
    checks++;
    if ({start_ready[0], busy[0], done_valid[0], error[0], stage_valid[0], stage_ack[0]} !== 12'b1000_0000_0000) begin
      errors++;
      $display("FAIL midreset_flags: rdy=%b busy=%b dv=%b err=%b valid=%b ack=%b, want 1 0 0 0 0000 0000",
               start_ready[0], busy[0], done_valid[0], error[0], stage_valid[0], stage_ack[0]);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tr0.delete();
    start_block(0, PT);
    wait_done(0, 3000, ok);
    checks++;
    if (ok !== 1'b1 || ciphertext[0] !== CT1) begin
      errors++;
      $display("FAIL midreset_ct: done=%b ct=%h, want 1 %h", ok, ciphertext[0], CT1);
    end
    checks++;
    if (tr0.size() != 40) begin
      errors++;
      $display("FAIL midreset_acks: got %0d acks, want 40", tr0.size());
    end
  endtask

  task automatic test_timeout;
    bit found;
    logic [127:0] snap, want;
    pulse_reset();
    mix_hang = 1'b1;
    found = 1'b0;
    start_block(0, PT);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (stage_valid[0] === 4'b0100) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (found !== 1'b1) begin
      errors++;
      $display("FAIL to_mix_issue: MIX issue not seen, got %b want 1", found);
    end
    want = stage_fn(1, stage_fn(0, PT ^ rk[0][0], 128'h0), 128'h0);
    snap = state_out[0];
    checks++;
    if (snap !== want || round[0] !== 4'd1) begin
      errors++;
      $display("FAIL to_mix_input: state=%h round=%0d, want %h 1", snap, round[0], want);
    end
    repeat (63) @(negedge clk);
    checks++;
    if (error[0] !== 1'b0 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL to_early: after 63 cycles error=%b busy=%b, want 0/1", error[0], busy[0]);
    end
    @(negedge clk);
    checks++;
    if (error[0] !== 1'b1) begin
      errors++;
      $display("FAIL to_fire: after 64 cycles error=%b, want 1", error[0]);
    end
    checks++;
    if ({stage_valid[0], stage_ack[0], start_ready[0], done_valid[0], busy[0]} !== 11'b0) begin
      errors++;
      $display("FAIL to_outputs: valid=%b ack=%b rdy=%b dv=%b busy=%b, want all 0",
               stage_valid[0], stage_ack[0], start_ready[0], done_valid[0], busy[0]);
    end
    start_valid[0] = 1'b1;
    repeat (5) @(negedge clk);
    start_valid[0] = 1'b0;
    checks++;
    if (error[0] !== 1'b1 || start_ready[0] !== 1'b0 || stage_valid[0] !== 4'b0 || state_out[0] !== snap) begin
      errors++;
      $display("FAIL to_sticky: error=%b rdy=%b valid=%b state=%h, want 1/0/0000 %h",
               error[0], start_ready[0], stage_valid[0], state_out[0], snap);
    end
    mix_hang = 1'b0;
  endtask

  task automatic test_c3;
    bit ok;
    pulse_reset();
    tr1.delete();
    start_block(1, PT);
    wait_done(1, 4000, ok);
    checks++;
    if (ok !== 1'b1 || ciphertext[1] !== CT3) begin
      errors++;
      $display("FAIL c3_ct: done=%b ct=%h, want 1 %h", ok, ciphertext[1], CT3);
    end
    checks++;
    if (tr1.size() != 56) begin
      errors++;
      $display("FAIL c3_acks: got %0d acks, want 56", tr1.size());
    end
    checks++;
    if (tr1.size() == 0 || tr1[tr1.size()-1] !== {4'd14, 4'b1000} || tr1[0] !== {4'd0, 4'b1000}) begin
      errors++;
      $display("FAIL c3_ends: first/last ack entries wrong, size=%0d, want 08 then e8", tr1.size());
    end
    done_ready[1] = 1'b1;
    @(negedge clk);
    done_ready[1] = 1'b0;
    checks++;
    if (start_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL c3_release: start_ready=%b, want 1", start_ready[1]);
    end
  endtask

  initial begin
    plaintext[0] = '0;
    plaintext[1] = '0;
    expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    expand(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    test_reset();
    test_c1();
    test_stage_trace();
    test_done_hold();
    test_reset_mid_block();
    test_timeout();
    test_c3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
